// File: rtl/branch_resolve_sched_pkg.sv
// Shared header types for the branch-resolution path: branch tag width,
// one-hot branch mask and the CDB packet the scheduler output feeds.
`ifndef BS_SIZE
`define BS_SIZE 4
`endif

package branch_resolve_sched_pkg;

   localparam int BRANCH_WIDTH = `BS_SIZE;

   typedef logic [BRANCH_WIDTH-1:0] BRANCH_MASK;

   typedef struct packed {
      logic       valid;
      logic       squash_enable;
      BRANCH_MASK branch_mask;
   } CDB_PACKET;

endpackage

// File: rtl/branch_resolve_sched_select.sv
// Tag-selection helpers: oldest (highest-index) request select, and the
// one-hot to thermometer expansion used to build a squash kill mask.

module branch_resolve_sched_prio #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] req,
   output logic [WIDTH-1:0] gnt,
   output logic             any
);

   // Later iterations overwrite earlier ones, so the highest set index wins.
   always_comb begin
      gnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (req[i]) begin
            gnt    = '0;
            gnt[i] = 1'b1;
         end
      end
      any = |req;
   end

endmodule

module branch_resolve_sched_therm #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] onehot,
   output logic [WIDTH-1:0] therm
);

   // Bit i is set when the one-hot bit sits at index i or above (bits k..0).
   always_comb begin
      logic acc;
      acc   = 1'b0;
      therm = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         acc      = acc | onehot[i];
         therm[i] = acc;
      end
   end

endmodule

// File: rtl/branch_resolve_sched.sv
// Collects branch resolutions from the branch units and serialises them onto
// the CDB one at a time, oldest mispredict first, with squash pruning.

module branch_resolve_sched
   import branch_resolve_sched_pkg::*;
#(
   parameter int N_BRU   = 2,
   parameter int BS_SIZE = `BS_SIZE
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [N_BRU-1:0]                  res_valid,
   input  logic [N_BRU-1:0][BS_SIZE-1:0]     res_mask,
   input  logic [N_BRU-1:0]                  res_mispredict,
   input  logic                              flush,
   input  logic                              out_grant,
   output logic                              out_valid,
   output logic                              out_squash,
   output logic [BS_SIZE-1:0]                out_mask,
   output logic [$clog2(BS_SIZE+1)-1:0]      pending_cnt,
   output logic                              dup_error
);

   localparam int CNT_W = $clog2(BS_SIZE + 1);

   logic [BS_SIZE-1:0] pending;
   logic [BS_SIZE-1:0] mispredict;
   logic [BS_SIZE-1:0] arr_pend;
   logic [BS_SIZE-1:0] arr_misp;
   logic [BS_SIZE-1:0] held_mask;
   logic [BS_SIZE-1:0] squash_tag;
   logic [BS_SIZE-1:0] kill_mask;
   logic [BS_SIZE-1:0] next_pending;
   logic [BS_SIZE-1:0] next_misp;
   logic [BS_SIZE-1:0] sel_misp;
   logic [BS_SIZE-1:0] sel_all;
   logic [BS_SIZE-1:0] sel_mask;
   logic               any_misp;
   logic               any_pend;
   logic               dup_now;
   logic               squash_fire;
   logic               load_out;

   // Merge all port arrivals; a tag already pending, held, or seen on an
   // earlier port this cycle is a duplicate and folds into a single entry.
   always_comb begin
      arr_pend  = '0;
      arr_misp  = '0;
      dup_now   = 1'b0;
      held_mask = out_valid ? out_mask : '0;
      for (int i = 0; i < N_BRU; i++) begin
         if (res_valid[i]) begin
            if ((res_mask[i] & (pending | held_mask | arr_pend)) != '0) begin
               dup_now = 1'b1;
            end
            arr_pend = arr_pend | res_mask[i];
            if (res_mispredict[i]) begin
               arr_misp = arr_misp | res_mask[i];
            end
         end
      end
   end

   assign squash_fire = out_valid & out_squash & out_grant;
   assign squash_tag  = squash_fire ? out_mask : '0;

   branch_resolve_sched_therm #(.WIDTH(BS_SIZE)) u_kill (
      .onehot (squash_tag),
      .therm  (kill_mask)
   );

   // Arrivals matching the held tag are dropped so a tag is never issued twice.
   assign next_pending = (pending | (arr_pend & ~held_mask)) & ~kill_mask;
   assign next_misp    = (mispredict | (arr_misp & ~held_mask)) & ~kill_mask;

   branch_resolve_sched_prio #(.WIDTH(BS_SIZE)) u_sel_misp (
      .req (next_misp),
      .gnt (sel_misp),
      .any (any_misp)
   );

   branch_resolve_sched_prio #(.WIDTH(BS_SIZE)) u_sel_all (
      .req (next_pending),
      .gnt (sel_all),
      .any (any_pend)
   );

   assign sel_mask = any_misp ? sel_misp : sel_all;
   assign load_out = ~out_valid | out_grant;

   // The held resolution is never preempted; it only changes once granted.
   always_ff @(posedge clock) begin
      if (reset) begin
         pending    <= '0;
         mispredict <= '0;
         out_valid  <= 1'b0;
         out_squash <= 1'b0;
         out_mask   <= '0;
         dup_error  <= 1'b0;
      end else if (flush) begin
         pending    <= '0;
         mispredict <= '0;
         out_valid  <= 1'b0;
         out_squash <= 1'b0;
         out_mask   <= '0;
      end else begin
         dup_error <= dup_error | dup_now;
         if (load_out) begin
            pending    <= next_pending & ~sel_mask;
            mispredict <= next_misp & ~sel_mask;
            out_valid  <= any_pend;
            out_squash <= any_misp;
            out_mask   <= sel_mask;
         end else begin
            pending    <= next_pending;
            mispredict <= next_misp;
         end
      end
   end

   always_comb begin
      pending_cnt = '0;
      for (int i = 0; i < BS_SIZE; i++) begin
         pending_cnt = pending_cnt + CNT_W'(pending[i]);
      end
   end

endmodule
